// File: rtl/image_pkg.sv
// Shared types and constants for the image pixel stage.
// The stage has a fixed two-stage pipeline and uses valid/ready handshaking on its input.
package image_pkg;

   localparam int PIX_W   = 8;
   localparam int ADDR_W  = 11;
   localparam int LATENCY = 2;

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_ADD    = 2'd1;
   localparam logic [1:0] MODE_SUB    = 2'd2;
   localparam logic [1:0] MODE_THRESH = 2'd3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   function automatic logic [PIX_W-1:0] add_sat(input logic [PIX_W-1:0] c,
                                                input logic [PIX_W-1:0] v);
      logic [PIX_W:0] s;
      s = {1'b0, c} + {1'b0, v};
      return s[PIX_W] ? {PIX_W{1'b1}} : s[PIX_W-1:0];
   endfunction

   // A borrow out of the 9-bit difference means the result went negative.
   function automatic logic [PIX_W-1:0] sub_sat(input logic [PIX_W-1:0] c,
                                                input logic [PIX_W-1:0] v);
      logic [PIX_W:0] d;
      d = {1'b0, c} - {1'b0, v};
      return d[PIX_W] ? {PIX_W{1'b0}} : d[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/image_pixel_stage_point_op.sv
// Combinational per-pixel point operation: pass, saturating add/sub, or luma threshold.
// Zero latency; no flow control of its own.
import image_pkg::*;

module pixel_point_op (
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] value,
   input  logic [PIX_W-1:0] threshold,
   input  logic [PIX_W-1:0] in_r,
   input  logic [PIX_W-1:0] in_g,
   input  logic [PIX_W-1:0] in_b,
   output logic [PIX_W-1:0] out_r,
   output logic [PIX_W-1:0] out_g,
   output logic [PIX_W-1:0] out_b
);

   logic [9:0] gray_sum;
   logic       hit;

   always_comb begin
      gray_sum = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
      hit      = (gray_sum >> 2) >= {2'b00, threshold};
      out_r    = in_r;
      out_g    = in_g;
      out_b    = in_b;
      case (mode)
         MODE_ADD: begin
            out_r = add_sat(in_r, value);
            out_g = add_sat(in_g, value);
            out_b = add_sat(in_b, value);
         end
         MODE_SUB: begin
            out_r = sub_sat(in_r, value);
            out_g = sub_sat(in_g, value);
            out_b = sub_sat(in_b, value);
         end
         MODE_THRESH: begin
            out_r = hit ? 8'hFF : 8'h00;
            out_g = hit ? 8'hFF : 8'h00;
            out_b = hit ? 8'hFF : 8'h00;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/image_pixel_stage.sv
// Frame-sequenced RGB point-operation stage feeding the BMP writer; 2-cycle input-to-output latency.
// in_ready is high only while RUN; the output side has no backpressure and holds data across bubbles.
import image_pkg::*;

module image_pixel_stage #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              start,
   input  logic [31:0]       width,
   input  logic [31:0]       height,
   input  logic [1:0]        mode,
   input  logic [7:0]        value,
   input  logic [7:0]        threshold,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_R,
   input  logic [7:0]        in_G,
   input  logic [7:0]        in_B,
   output logic [7:0]        DATA_WRITE_R,
   output logic [7:0]        DATA_WRITE_G,
   output logic [7:0]        DATA_WRITE_B,
   output logic [ADDR_W-1:0] row,
   output logic [ADDR_W-1:0] col,
   output logic              out_valid,
   output logic              busy,
   output logic              frame_done
);

   state_t            state, state_nxt;
   logic [1:0]        cfg_mode;
   logic [PIX_W-1:0]  cfg_value, cfg_thresh;
   logic [ADDR_W-1:0] last_col, last_row;
   logic [ADDR_W-1:0] in_col, in_row;
   logic              hs, start_ok, last_px;

   logic              s1_valid;
   logic [PIX_W-1:0]  s1_r, s1_g, s1_b;
   logic [ADDR_W-1:0] s1_row, s1_col;
   logic [PIX_W-1:0]  op_r, op_g, op_b;

   assign start_ok = start && (state == IDLE)
                     && (width != 32'd0) && (height != 32'd0)
                     && (width <= 32'(WIDTH)) && (height <= 32'(HEIGHT));
   assign hs       = in_valid && in_ready;
   assign last_px  = hs && (in_row == last_row) && (in_col == last_col);

   assign in_ready   = (state == RUN);
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // DRAIN leaves once stage 1 is empty: the edge that takes us to DONE also empties stage 2.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = RUN;
         RUN:     if (last_px)  state_nxt = DRAIN;
         DRAIN:   if (!s1_valid) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         cfg_mode   <= MODE_PASS;
         cfg_value  <= '0;
         cfg_thresh <= '0;
         last_col   <= '0;
         last_row   <= '0;
         in_col     <= '0;
         in_row     <= '0;
      end else if (start_ok) begin
         cfg_mode   <= mode;
         cfg_value  <= value;
         cfg_thresh <= threshold;
         last_col   <= width[ADDR_W-1:0] - 11'd1;
         last_row   <= height[ADDR_W-1:0] - 11'd1;
         in_col     <= '0;
         in_row     <= '0;
      end else if (hs) begin
         if (in_col == last_col) begin
            in_col <= '0;
            in_row <= in_row + 11'd1;
         end else begin
            in_col <= in_col + 11'd1;
         end
      end
   end

   pixel_point_op u_op (
      .mode      (cfg_mode),
      .value     (cfg_value),
      .threshold (cfg_thresh),
      .in_r      (s1_r),
      .in_g      (s1_g),
      .in_b      (s1_b),
      .out_r     (op_r),
      .out_g     (op_g),
      .out_b     (op_b)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         s1_valid     <= 1'b0;
         s1_r         <= '0;
         s1_g         <= '0;
         s1_b         <= '0;
         s1_row       <= '0;
         s1_col       <= '0;
         out_valid    <= 1'b0;
         DATA_WRITE_R <= '0;
         DATA_WRITE_G <= '0;
         DATA_WRITE_B <= '0;
         row          <= '0;
         col          <= '0;
      end else begin
         s1_valid  <= hs;
         out_valid <= s1_valid;
         if (hs) begin
            s1_r   <= in_R;
            s1_g   <= in_G;
            s1_b   <= in_B;
            s1_row <= in_row;
            s1_col <= in_col;
         end
         if (s1_valid) begin
            DATA_WRITE_R <= op_r;
            DATA_WRITE_G <= op_g;
            DATA_WRITE_B <= op_b;
            row          <= s1_row;
            col          <= s1_col;
         end
      end
   end

endmodule

// File: tb/tb_image_pixel_stage.sv
// Directed bench for image_pixel_stage: point-op vector table plus frame sequencing corner cases.
module tb_image_pixel_stage;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        start;
   logic [31:0] width, height;
   logic [1:0]  mode;
   logic [7:0]  value, threshold;
   logic        in_valid, in_ready;
   logic [7:0]  in_R, in_G, in_B;
   logic [7:0]  DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B;
   logic [10:0] row, col;
   logic        out_valid, busy, frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   image_pixel_stage dut (
      .HCLK(HCLK), .HRESET(HRESET), .start(start), .width(width), .height(height),
      .mode(mode), .value(value), .threshold(threshold),
      .in_valid(in_valid), .in_ready(in_ready), .in_R(in_R), .in_G(in_G), .in_B(in_B),
      .DATA_WRITE_R(DATA_WRITE_R), .DATA_WRITE_G(DATA_WRITE_G), .DATA_WRITE_B(DATA_WRITE_B),
      .row(row), .col(col), .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [1:0] md;
      logic [7:0] val, thr;
      logic [7:0] r, g, b;
      logic [7:0] er, eg, eb;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   function automatic logic [31:0] rgb();
      return {8'h00, DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B};
   endfunction

   // Runs until busy drops (bounded), expecting exactly one frame_done pulse.
   task automatic wait_idle(input string nm);
      int cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (frame_done) cnt++;
         if (!busy) break;
         tick();
      end
      check({nm, "_idle"}, 32'(busy), 32'd0);
      check({nm, "_done_cnt"}, 32'(cnt), 32'd1);
   endtask

   task automatic set_cfg(input int w, input int h, input logic [1:0] md,
                          input logic [7:0] val, input logic [7:0] thr);
      width = w; height = h; mode = md; value = val; threshold = thr;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      set_cfg(1, 1, v.md, v.val, v.thr);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_R = v.r; in_G = v.g; in_B = v.b;
      tick();
      in_valid = 1'b0;
      tick();
      check($sformatf("vec%0d_vld", k), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_rgb", k), rgb(), {8'h00, v.er, v.eg, v.eb});
      wait_idle($sformatf("vec%0d", k));
   endtask

   // 4x2 pass-through frame, R=G=B=pixel index, in_valid held high.
   task automatic frame_4x2(input string nm);
      logic exp_v;
      int   idx;
      set_cfg(4, 2, 2'd0, 8'd0, 8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_R = 8'd0; in_G = 8'd0; in_B = 8'd0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         exp_v = (n >= 2) && (n <= 9);
         check($sformatf("%s_vld_e%0d", nm, n), 32'(out_valid), 32'(exp_v));
         if (exp_v) begin
            idx = n - 2;
            check($sformatf("%s_row_e%0d", nm, n), 32'(row), 32'(idx / 4));
            check($sformatf("%s_col_e%0d", nm, n), 32'(col), 32'(idx % 4));
            check($sformatf("%s_rgb_e%0d", nm, n), rgb(), {8'h00, 8'(idx), 8'(idx), 8'(idx)});
         end
         check($sformatf("%s_done_e%0d", nm, n), 32'(frame_done), 32'(n == 10));
         check($sformatf("%s_busy_e%0d", nm, n), 32'(busy), 32'(n <= 10));
         if (n < 8) begin
            in_R = 8'(n); in_G = 8'(n); in_B = 8'(n);
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_vld"},  32'(out_valid), 32'd0);
      check({nm, "_rgb"},  rgb(), 32'd0);
      check({nm, "_rc"},   {10'd0, row, col}, 32'd0);
      check({nm, "_busy"}, 32'(busy), 32'd0);
      check({nm, "_rdy"},  32'(in_ready), 32'd0);
      check({nm, "_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      logic [7:0] ga [3];
      int pulses;

      vecs[0] = '{2'd0, 8'd0,   8'd0,   8'd12,  8'd34,  8'd56,  8'd12,  8'd34,  8'd56};
      vecs[1] = '{2'd1, 8'd100, 8'd0,   8'd200, 8'd50,  8'd155, 8'd255, 8'd150, 8'd255};
      vecs[2] = '{2'd2, 8'd100, 8'd0,   8'd200, 8'd50,  8'd155, 8'd100, 8'd0,   8'd55};
      vecs[3] = '{2'd3, 8'd0,   8'd128, 8'd100, 8'd150, 8'd200, 8'd255, 8'd255, 8'd255};
      vecs[4] = '{2'd3, 8'd0,   8'd128, 8'd0,   8'd127, 8'd255, 8'd0,   8'd0,   8'd0};
      vecs[5] = '{2'd3, 8'd0,   8'd150, 8'd100, 8'd150, 8'd200, 8'd255, 8'd255, 8'd255};
      vecs[6] = '{2'd1, 8'd55,  8'd0,   8'd200, 8'd0,   8'd201, 8'd255, 8'd55,  8'd255};
      vecs[7] = '{2'd2, 8'd1,   8'd0,   8'd0,   8'd1,   8'd255, 8'd0,   8'd0,   8'd254};
      vecs[8] = '{2'd3, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255};

      HRESET = 1'b1; start = 1'b0; in_valid = 1'b0;
      in_R = 8'd0; in_G = 8'd0; in_B = 8'd0;
      set_cfg(0, 0, 2'd0, 8'd0, 8'd0);
      #12;
      check_all_zero("reset");
      @(negedge HCLK);
      HRESET = 1'b0;
      tick();

      frame_4x2("base");

      foreach (vecs[k]) run_vec(k, vecs[k]);

      // 3x1 frame with in_valid toggling: handshakes on edges 1, 3, 5.
      set_cfg(3, 1, 2'd0, 8'd0, 8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      pulses = 0;
      ga[0] = 8'd10; ga[1] = 8'd20; ga[2] = 8'd30;
      in_valid = 1'b1; in_R = ga[0]; in_G = ga[0]; in_B = ga[0];
      for (int n = 1; n <= 9; n++) begin
         int k;
         tick();
         k = (n < 2) ? 0 : ((n >= 6) ? 2 : (n - 2) / 2);
         if (out_valid) pulses++;
         check($sformatf("gap_vld_e%0d", n), 32'(out_valid), 32'((n == 2) || (n == 4) || (n == 6)));
         if (n >= 2) begin
            check($sformatf("gap_col_e%0d", n), 32'(col), 32'(k));
            check($sformatf("gap_rgb_e%0d", n), rgb(), {8'h00, ga[k], ga[k], ga[k]});
         end
         check($sformatf("gap_rdy_e%0d", n), 32'(in_ready), 32'(n < 5));
         check($sformatf("gap_done_e%0d", n), 32'(frame_done), 32'(n == 7));
         if (n == 1 || n == 3) begin
            in_valid = 1'b0; in_R = 8'd99; in_G = 8'd99; in_B = 8'd99;
         end else if (n == 2 || n == 4) begin
            in_valid = 1'b1; in_R = ga[n / 2]; in_G = ga[n / 2]; in_B = ga[n / 2];
         end else begin
            in_valid = 1'b0;
         end
      end
      check("gap_pulses", 32'(pulses), 32'd3);

      // Mid-frame start with width=0 and new mode must not disturb a 2x1 pass frame.
      set_cfg(2, 1, 2'd0, 8'd0, 8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_R = 8'd1; in_G = 8'd2; in_B = 8'd3;
      tick();
      start = 1'b1; set_cfg(0, 1, 2'd1, 8'd100, 8'd0);
      in_R = 8'd4; in_G = 8'd5; in_B = 8'd6;
      tick();
      start = 1'b0; in_valid = 1'b0;
      check("mid_rgb0", rgb(), 32'h00010203);
      check("mid_col0", 32'(col), 32'd0);
      tick();
      check("mid_rgb1", rgb(), 32'h00040506);
      check("mid_col1", 32'(col), 32'd1);
      wait_idle("mid");

      // Illegal starts while IDLE are dropped.
      for (int t = 0; t < 3; t++) begin
         if (t == 0) set_cfg(0, 2, 2'd0, 8'd0, 8'd0);
         else if (t == 1) set_cfg(769, 1, 2'd0, 8'd0, 8'd0);
         else set_cfg(768, 513, 2'd0, 8'd0, 8'd0);
         start = 1'b1;
         tick();
         start = 1'b0;
         pulses = 0;
         for (int n = 0; n < 4; n++) begin
            if (busy || frame_done) pulses++;
            tick();
         end
         check($sformatf("badstart%0d", t), 32'(pulses), 32'd0);
      end

      // Asynchronous reset after three accepted pixels abandons the frame.
      set_cfg(4, 2, 2'd0, 8'd0, 8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         in_R = 8'(n + 1); in_G = 8'(n + 1); in_B = 8'(n + 1);
         tick();
      end
      check("pre_rst_vld", 32'(out_valid), 32'd1);
      #2 HRESET = 1'b1;
      #1;
      check_all_zero("midrst");
      #1 HRESET = 1'b0;
      in_valid = 1'b0;
      pulses = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (busy || frame_done || out_valid) pulses++;
      end
      check("post_rst_quiet", 32'(pulses), 32'd0);

      frame_4x2("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/image_pixel_stage.md
Name: image_pixel_stage

Overview:
- Upstream neighbour of the BMP writer stage.
- Accepts a raster-ordered RGB888 pixel stream from the image reader and applies one selectable point operation: pass-through, brightness add, brightness subtract, or threshold.
- Emits per-pixel DATA_WRITE_R/G/B together with the row and col address, in the form the writer consumes.
- Owns frame sequencing: start, row/col counting, end-of-frame pulse.

Parameters:
- WIDTH, 768, maximum image width supported; col counter range.
- HEIGHT, 512, maximum image height supported; row counter range.
- LATENCY, 2, fixed pipeline depth from accepted input pixel to output pixel (not overridable; documentation constant).

Ports:
- HCLK  input  1  clock, all state on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame when IDLE.
- width  input  32  active frame width in pixels; sampled on accepted start.
- height  input  32  active frame height in pixels; sampled on accepted start.
- mode  input  2  0 pass, 1 add, 2 sub, 3 threshold; sampled on accepted start.
- value  input  8  brightness offset for add/sub; sampled on accepted start.
- threshold  input  8  threshold level for mode 3; sampled on accepted start.
- in_valid  input  1  input pixel present.
- in_ready  output  1  stage accepts input this cycle.
- in_R, in_G, in_B  input  8 each  input pixel.
- DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B  output  8 each  processed pixel.
- row  output  11  row of the current output pixel, 0 = top.
- col  output  11  column of the current output pixel.
- out_valid  output  1  output pixel/address valid this cycle.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last pixel leaves the pipeline.

Behaviour:
- Reset (async, HRESET=1): all outputs 0, state IDLE, counters 0, pipeline valid bits cleared. This applies mid-frame too: the frame is abandoned and no frame_done is issued.
- FSM states:
  - IDLE: start=1 with width≠0, height≠0, width≤WIDTH, height≤HEIGHT latches the config, clears counters and goes to RUN. Any other start is ignored and the block stays IDLE.
  - RUN: in_ready=1. Handshake = in_valid & in_ready. Each handshake advances the input-side col; at col==width-1, col wraps to 0 and row increments. The handshake on the pixel at (height-1, width-1) moves the FSM to DRAIN and drops in_ready the next cycle.
  - DRAIN: in_ready=0. Waits until the pipeline is empty, then goes to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- start while not IDLE is ignored. Config inputs changing mid-frame have no effect.
- in_valid low stalls counters and inserts bubbles. out_valid=0 on bubbles.
- During bubbles, outputs hold their last values. The writer rewriting the same address with the same data is harmless.
- Pipeline:
  - Stage 1 registers the pixel, its row/col and a valid bit.
  - Stage 2 registers the op result.
  - out_valid asserts exactly 2 cycles after a handshake.
- Arithmetic (9-bit internal):
  - Mode 1: per channel min(c+value, 255).
  - Mode 2: per channel max(c-value, 0).
  - Mode 3: gray=(R+2G+B)>>2, using a 10-bit sum. All channels are 255 if gray≥threshold, else 0.
  - Mode 0: unchanged.
- row/col outputs are 11 bits; the width/height upper bits are only used for the range check.
- busy=1 in RUN, DRAIN and DONE.

Decomposition:
- Shared package image_pkg holds:
  - Mode constants MODE_PASS=0, MODE_ADD=1, MODE_SUB=2, MODE_THRESH=3.
  - FSM state encoding IDLE/RUN/DRAIN/DONE.
  - Constants PIX_W=8 and ADDR_W=11.
- One sub-module, pixel_point_op: purely combinational mode/value/threshold + RGB in → RGB out. It is instantiated between stage 1 and stage 2 and is unit-testable alone.

Test Plan:
- Reset, width=4, height=2, mode=0, start, in_valid held high, pixels i=0..7 with R=G=B=i → out_valid high for cycles 3..10 after start accept. (row,col) sequence is (0,0)…(0,3),(1,0)…(1,3); data equals input; frame_done pulses once, 1 cycle after the last out_valid.
- mode=1, value=100, pixels R=200, G=50, B=155 → outputs 255, 150, 255. Then mode=2, value=100 → outputs 100, 0, 55.
- mode=3, threshold=128, pixel (100,150,200) → gray=150 → 255,255,255. Pixel (0,127,255) → gray=127 → 0,0,0.
- width=3, height=1, in_valid toggling 1,0,1,0,1 → exactly 3 out_valid pulses with col 0,1,2. Outputs hold their last values during gaps. in_ready=0 after the third handshake.
- start re-pulsed mid-frame with width=0 → ignored, frame completes normally. start with width=0 while IDLE → busy stays 0, no frame_done.
- HRESET asserted after 3 of 8 pixels → outputs 0 immediately, state IDLE, no frame_done. A subsequent start runs a full 8-pixel frame correctly from (0,0).
